// File: rtl/jpeg_bitstream_sync_fifo_pkg.sv
// Shared widths, depth and default thresholds for the JPEG bitstream output FIFO.
package jpeg_bitstream_fifo_pkg;
  localparam int DATA_WIDTH           = 32;
  localparam int DEPTH_WIDTH          = 12;
  localparam int DEPTH                = 2 ** DEPTH_WIDTH;
  localparam int DEF_ALMOST_FULL_NUM  = 2000;
  localparam int DEF_ALMOST_EMPTY_NUM = 2000;

  typedef logic [DATA_WIDTH-1:0]  word_t;
  typedef logic [DEPTH_WIDTH-1:0] addr_t;
  typedef logic [DEPTH_WIDTH:0]   level_t;

  function automatic level_t to_level(input int n);
    return level_t'(n);
  endfunction
endpackage

// File: rtl/jpeg_bitstream_sync_fifo_if.sv
// Write/read handshake and status bundle between the encoder, the FIFO and the consumer.
interface jpeg_bitstream_sync_fifo_if;
  import jpeg_bitstream_fifo_pkg::*;

  word_t  wr_data;
  logic   wr_en;
  logic   wr_full;
  logic   almost_full;
  word_t  rd_data;
  logic   rd_en;
  logic   rd_empty;
  level_t rd_water_level;
  logic   almost_empty;

  modport master (
    output wr_data, wr_en, rd_en,
    input  wr_full, almost_full, rd_data, rd_empty, rd_water_level, almost_empty
  );

  modport slave (
    input  wr_data, wr_en, rd_en,
    output wr_full, almost_full, rd_data, rd_empty, rd_water_level, almost_empty
  );
endinterface

// File: rtl/jpeg_bitstream_sync_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port; block-RAM inferable.
module jpeg_bitstream_fifo_ram
  import jpeg_bitstream_fifo_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  wr_en,
  input  addr_t wr_addr,
  input  word_t wr_data,
  input  logic  rd_en,
  input  addr_t rd_addr,
  output word_t rd_data
);

  word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  // Output register holds its value when no read is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_data <= '0;
    else if (rd_en)
      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/jpeg_bitstream_sync_fifo.sv
// 4096 x 32 single-clock FIFO for the JPEG encoder output: pointers, level and flag decode.
module jpeg_bitstream_sync_fifo
  import jpeg_bitstream_fifo_pkg::*;
#(
  parameter int ALMOST_FULL_NUM  = DEF_ALMOST_FULL_NUM,
  parameter int ALMOST_EMPTY_NUM = DEF_ALMOST_EMPTY_NUM
) (
  input  logic                      clk,
  input  logic                      tb_rst,
  jpeg_bitstream_sync_fifo_if.slave bus
);

  localparam level_t LVL_ONE  = to_level(1);
  localparam level_t LVL_FULL = to_level(DEPTH);
  localparam level_t LVL_AF   = to_level(ALMOST_FULL_NUM);
  localparam level_t LVL_AE   = to_level(ALMOST_EMPTY_NUM);

  level_t wptr;
  level_t rptr;
  level_t count;
  logic   full;
  logic   empty;
  logic   wr_acc;
  logic   rd_acc;

  // The extra pointer MSB is the wrap bit, so the difference spans 0..DEPTH.
  assign count  = wptr - rptr;
  assign full   = (count == LVL_FULL);
  assign empty  = (count == '0);
  assign wr_acc = bus.wr_en & ~full;
  assign rd_acc = bus.rd_en & ~empty;

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc)
        wptr <= wptr + LVL_ONE;
      if (rd_acc)
        rptr <= rptr + LVL_ONE;
    end
  end

  jpeg_bitstream_fifo_ram u_ram (
    .clk     (clk),
    .rst     (tb_rst),
    .wr_en   (wr_acc),
    .wr_addr (wptr[DEPTH_WIDTH-1:0]),
    .wr_data (bus.wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rptr[DEPTH_WIDTH-1:0]),
    .rd_data (bus.rd_data)
  );

  assign bus.wr_full        = full;
  assign bus.rd_empty       = empty;
  assign bus.almost_full    = (count >= LVL_AF);
  assign bus.almost_empty   = (count <= LVL_AE);
  assign bus.rd_water_level = count;

endmodule

// File: tb/tb_jpeg_bitstream_sync_fifo.sv
// Self-checking bench for jpeg_bitstream_sync_fifo against a queue-based reference model.
module tb_jpeg_bitstream_sync_fifo;
  import jpeg_bitstream_fifo_pkg::*;

  logic clk = 1'b0;
  logic tb_rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  word_t q[$];
  word_t m_rd = '0;

  jpeg_bitstream_sync_fifo_if bus();

  jpeg_bitstream_sync_fifo dut (
    .clk    (clk),
    .tb_rst (tb_rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; model applies the FIFO rules after the edge.
  task automatic step(input logic we, input word_t wd, input logic re);
    bit wa, ra;
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    @(posedge clk);
    #1;
    wa = we && (q.size() < DEPTH);
    ra = re && (q.size() > 0);
    if (ra) m_rd = q.pop_front();
    if (wa) q.push_back(wd);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic do_reset();
    tb_rst = 1'b1;
    @(posedge clk);
    #1;
    tb_rst = 1'b0;
    q.delete();
    m_rd = '0;
  endtask

  task automatic test_reset();
    tb_rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.wr_data = '0;
    #12;
    tb_rst = 1'b0;
    q.delete();
    m_rd = '0;
    repeat (3) step(1'b0, '0, 1'b0);
    checks++; if (bus.rd_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b want=1", bus.rd_empty); end
    checks++; if (bus.almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty got=%b want=1", bus.almost_empty); end
    checks++; if (bus.wr_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b want=0", bus.wr_full); end
    checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full got=%b want=0", bus.almost_full); end
    checks++; if (bus.rd_water_level !== '0) begin errors++; $display("FAIL reset_level got=%0d want=0", bus.rd_water_level); end
    checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got=%h want=0", bus.rd_data); end
  endtask

  task automatic test_fill();
    for (int i = 0; i <= DEPTH; i++) begin
      step(1'b1, 32'hFFFF_FFFF - word_t'(i), 1'b0);
      checks++; if (bus.rd_water_level !== level_t'(q.size())) begin errors++; $display("FAIL fill_level i=%0d got=%0d want=%0d", i, bus.rd_water_level, q.size()); end
      checks++; if (bus.almost_full !== (q.size() >= 2000)) begin errors++; $display("FAIL fill_almost_full i=%0d got=%b want=%b", i, bus.almost_full, q.size() >= 2000); end
      checks++; if (bus.almost_empty !== (q.size() <= 2000)) begin errors++; $display("FAIL fill_almost_empty i=%0d got=%b want=%b", i, bus.almost_empty, q.size() <= 2000); end
      checks++; if (bus.wr_full !== (q.size() == DEPTH)) begin errors++; $display("FAIL fill_full i=%0d got=%b want=%b", i, bus.wr_full, q.size() == DEPTH); end
    end
    checks++; if (bus.rd_water_level !== 13'd4096) begin errors++; $display("FAIL fill_final_level got=%0d want=4096", bus.rd_water_level); end
    checks++; if (bus.wr_full !== 1'b1) begin errors++; $display("FAIL fill_final_full got=%b want=1", bus.wr_full); end
  endtask

  task automatic test_drain();
    for (int i = 0; i <= DEPTH; i++) begin
      step(1'b0, '0, 1'b1);
      checks++; if (bus.rd_data !== m_rd) begin errors++; $display("FAIL drain_data i=%0d got=%h want=%h", i, bus.rd_data, m_rd); end
      checks++; if (bus.rd_water_level !== level_t'(q.size())) begin errors++; $display("FAIL drain_level i=%0d got=%0d want=%0d", i, bus.rd_water_level, q.size()); end
      checks++; if (bus.rd_empty !== (q.size() == 0)) begin errors++; $display("FAIL drain_empty i=%0d got=%b want=%b", i, bus.rd_empty, q.size() == 0); end
    end
    checks++; if (bus.rd_data !== 32'hFFFF_F000) begin errors++; $display("FAIL drain_last_data got=%h want=fffff000", bus.rd_data); end
    checks++; if (bus.rd_empty !== 1'b1) begin errors++; $display("FAIL drain_final_empty got=%b want=1", bus.rd_empty); end
  endtask

  task automatic test_concurrent();
    for (int i = 0; i < 10; i++) step(1'b1, word_t'($urandom), 1'b0);
    for (int i = 0; i < 100; i++) begin
      step(1'b1, word_t'($urandom), 1'b1);
      checks++; if (bus.rd_water_level !== 13'd10) begin errors++; $display("FAIL conc_level i=%0d got=%0d want=10", i, bus.rd_water_level); end
      checks++; if (bus.rd_data !== m_rd) begin errors++; $display("FAIL conc_data i=%0d got=%h want=%h", i, bus.rd_data, m_rd); end
    end
  endtask

  task automatic test_empty_rw();
    word_t prev;
    int guard = 0;
    while (q.size() > 0 && guard < 2 * DEPTH) begin
      step(1'b0, '0, 1'b1);
      guard++;
    end
    checks++; if (bus.rd_empty !== 1'b1) begin errors++; $display("FAIL empty_rw_pre_empty got=%b want=1", bus.rd_empty); end
    prev = m_rd;
    step(1'b1, 32'hA5A5_1234, 1'b1);
    checks++; if (bus.rd_water_level !== 13'd1) begin errors++; $display("FAIL empty_rw_level got=%0d want=1", bus.rd_water_level); end
    checks++; if (bus.rd_data !== prev) begin errors++; $display("FAIL empty_rw_data got=%h want=%h", bus.rd_data, prev); end
    step(1'b0, '0, 1'b1);
    checks++; if (bus.rd_data !== 32'hA5A5_1234) begin errors++; $display("FAIL empty_rw_next got=%h want=a5a51234", bus.rd_data); end
  endtask

  task automatic test_full_rw();
    int guard = 0;
    while (q.size() < DEPTH && guard < 2 * DEPTH) begin
      step(1'b1, word_t'($urandom), 1'b0);
      guard++;
    end
    checks++; if (bus.wr_full !== 1'b1) begin errors++; $display("FAIL full_rw_pre_full got=%b want=1", bus.wr_full); end
    step(1'b1, 32'hDEAD_BEEF, 1'b1);
    checks++; if (bus.rd_water_level !== 13'd4095) begin errors++; $display("FAIL full_rw_level got=%0d want=4095", bus.rd_water_level); end
    checks++; if (bus.wr_full !== 1'b0) begin errors++; $display("FAIL full_rw_full got=%b want=0", bus.wr_full); end
    checks++; if (bus.rd_data !== m_rd) begin errors++; $display("FAIL full_rw_data got=%h want=%h", bus.rd_data, m_rd); end
  endtask

  task automatic test_reset_midway();
    do_reset();
    for (int i = 0; i < 3001; i++) step(1'b1, word_t'($urandom) | 32'h1, 1'b0);
    step(1'b0, '0, 1'b1);
    checks++; if (bus.rd_water_level !== 13'd3000) begin errors++; $display("FAIL mid_pre_level got=%0d want=3000", bus.rd_water_level); end
    checks++; if (bus.rd_data !== m_rd) begin errors++; $display("FAIL mid_pre_data got=%h want=%h", bus.rd_data, m_rd); end
    #2;
    tb_rst = 1'b1;
    #1;
    q.delete();
    m_rd = '0;
    checks++; if (bus.rd_empty !== 1'b1) begin errors++; $display("FAIL mid_rst_empty got=%b want=1", bus.rd_empty); end
    checks++; if (bus.almost_empty !== 1'b1) begin errors++; $display("FAIL mid_rst_almost_empty got=%b want=1", bus.almost_empty); end
    checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL mid_rst_almost_full got=%b want=0", bus.almost_full); end
    checks++; if (bus.wr_full !== 1'b0) begin errors++; $display("FAIL mid_rst_full got=%b want=0", bus.wr_full); end
    checks++; if (bus.rd_water_level !== '0) begin errors++; $display("FAIL mid_rst_level got=%0d want=0", bus.rd_water_level); end
    checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL mid_rst_data got=%h want=0", bus.rd_data); end
    @(posedge clk);
    #1;
    tb_rst = 1'b0;
    step(1'b1, 32'h0BAD_F00D, 1'b0);
    step(1'b0, '0, 1'b1);
    checks++; if (bus.rd_data !== 32'h0BAD_F00D) begin errors++; $display("FAIL mid_post_data got=%h want=0badf00d", bus.rd_data); end
    checks++; if (bus.rd_empty !== 1'b1) begin errors++; $display("FAIL mid_post_empty got=%b want=1", bus.rd_empty); end
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.wr_data = '0;
    test_reset();
    test_fill();
    test_drain();
    test_concurrent();
    test_empty_rw();
    test_full_rw();
    test_reset_midway();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
